// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// State encoding is one-hot so each state decodes from a single flop.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    START   = 6'b000010,
    DATA    = 6'b000100,
    PARITY  = 6'b001000,
    STOP    = 6'b010000,
    RECOVER = 6'b100000
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so an idle (high) line never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive front end: frames start/data/parity/stop bits from the
// oversampled rx line and pushes good characters into the RX FIFO.
module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = UART_DEFAULT_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 full,
  output logic                 write,
  output logic [DATA_BITS-1:0] write_data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);
  localparam logic              ODD_BIT   = (PARITY_ODD != 0);
  localparam rx_state_e         AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

  logic rx_s;

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_bad_q, parity_bad_d;
  logic                 write_q, write_d;
  logic [DATA_BITS-1:0] write_data_q, write_data_d;
  logic                 parity_error_q, parity_error_d;
  logic                 framing_error_q, framing_error_d;
  logic                 overrun_error_q, overrun_error_d;
  logic                 mid_bit;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign mid_bit = (tick_cnt_q == LAST_TICK);

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    parity_bad_d    = parity_bad_q;
    write_d         = 1'b0;
    write_data_d    = write_data_q;
    parity_error_d  = 1'b0;
    framing_error_d = 1'b0;
    overrun_error_d = 1'b0;

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d      = START;
            tick_cnt_d   = '0;
            bit_cnt_d    = '0;
            parity_bad_d = 1'b0;
          end
        end
        // Re-check the line half a bit in to reject glitches as false starts.
        START: begin
          if (tick_cnt_q == MID_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              state_d   = AFTER_DATA;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (mid_bit) begin
            tick_cnt_d   = '0;
            parity_bad_d = ((^shift_q) ^ rx_s) != ODD_BIT;
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        // Only one outcome is reported per frame; a low stop bit wins over all.
        STOP: begin
          if (mid_bit) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              framing_error_d = 1'b1;
              state_d         = RECOVER;
            end else if (parity_bad_q) begin
              parity_error_d = 1'b1;
              state_d        = IDLE;
            end else if (full) begin
              overrun_error_d = 1'b1;
              state_d         = IDLE;
            end else begin
              write_d      = 1'b1;
              write_data_d = shift_q;
              state_d      = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        RECOVER: begin
          if (rx_s) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d    = IDLE;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      parity_bad_q    <= 1'b0;
      write_q         <= 1'b0;
      write_data_q    <= '0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      parity_bad_q    <= parity_bad_d;
      write_q         <= write_d;
      write_data_q    <= write_data_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      overrun_error_q <= overrun_error_d;
    end
  end

  assign write         = write_q;
  assign write_data    = write_data_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign overrun_error = overrun_error_q;
  assign busy          = (state_q != IDLE);

endmodule
